alu_sequencer: RTL and testbench

Command-side driver for the 32-bit combinational ALU. It accepts one operation at a time over a valid/ready command port and registers the operands and select code onto the ALU inputs. After a programmable settle time it captures the ALU result and returns it, with a zero flag, over a valid/ready response port. It sits between the instruction/control path and the ALU, so the ALU's combinational path is fully registered on both sides.

---
 rtl/alu_sequencer.sv | 118 +++++++++++
 tb/tb_alu_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Command-side driver for the combinational ALU: registers one operation onto the ALU
// inputs, waits SETTLE cycles, captures alu_y and returns it over a valid/ready port.
module alu_sequencer #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_select,
  input  logic [WIDTH-1:0] alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic [2:0]       rsp_op,
  output logic             busy,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);

  state_t      state;
  state_t      state_next;
  logic [3:0]  settle_cnt;
  logic [15:0] done_count;
  logic        accept;
  logic        capture;
  logic        retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    capture    = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (settle_cnt == 4'd0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          retire     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ALU operands are only rewritten on accept so the ALU does not toggle between commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= 3'b111;
      rsp_op     <= 3'b111;
    end else if (accept) begin
      alu_a      <= cmd_a;
      alu_b      <= cmd_b;
      alu_select <= cmd_op;
      rsp_op     <= cmd_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   settle_cnt <= 4'd0;
    else if (accept)                              settle_cnt <= SETTLE_INIT;
    else if (state == WAIT && settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b1;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_y;
      rsp_zero  <= (alu_y == '0);
    end else if (retire) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      done_count <= 16'd0;
    else if (retire) done_count <= done_count + 16'd1;
  end

  assign op_count = done_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: three instances (SETTLE 1, 0, 15) each driven
// by a behavioural ALU, checked against a reference model of the operation and timing rules.
module tb_alu_sequencer;

  localparam int W = 32;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [2:0]   cmd_op = 3'd0;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;

  logic         cv   [N];
  logic         rr   [N];
  logic         cr   [N];
  logic         rv   [N];
  logic         rz   [N];
  logic         bsy  [N];
  logic [W-1:0] aa   [N];
  logic [W-1:0] ab   [N];
  logic [W-1:0] ay   [N];
  logic [W-1:0] rd   [N];
  logic [2:0]   asel [N];
  logic [2:0]   rop  [N];
  logic [15:0]  cnt  [N];

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int acc_cycle;

  logic [2:0]   cur_op  [N];
  logic [W-1:0] cur_a   [N];
  logic [W-1:0] cur_b   [N];
  logic [15:0]  exp_cnt [N];

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 15);
  endfunction

  // What the ALU is documented to compute for each select code
  function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      3'd0:    return a;
      3'd1:    return a - b;
      3'd2:    return a + b;
      3'd3:    return (a < b) ? W'(1) : W'(0);
      3'd4:    return a ^ b;
      3'd5:    return a + ~b + W'(1);
      3'd6:    return a * b;
      default: return '0;
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int S = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
    assign ay[g] = alu_ref(asel[g], aa[g], ab[g]);
    alu_sequencer #(.WIDTH(W), .SETTLE(S)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cv[g]),
      .cmd_ready  (cr[g]),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .alu_a      (aa[g]),
      .alu_b      (ab[g]),
      .alu_select (asel[g]),
      .alu_y      (ay[g]),
      .rsp_valid  (rv[g]),
      .rsp_ready  (rr[g]),
      .rsp_data   (rd[g]),
      .rsp_zero   (rz[g]),
      .rsp_op     (rop[g]),
      .busy       (bsy[g]),
      .op_count   (cnt[g])
    );
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input int d);
    checkOutput("rst_cmd_ready", 32'(cr[d]), 32'd1);
    checkOutput("rst_busy", 32'(bsy[d]), 32'd0);
    checkOutput("rst_alu_a", aa[d], 32'd0);
    checkOutput("rst_alu_b", ab[d], 32'd0);
    checkOutput("rst_alu_select", 32'(asel[d]), 32'd7);
    checkOutput("rst_rsp_valid", 32'(rv[d]), 32'd0);
    checkOutput("rst_rsp_data", rd[d], 32'd0);
    checkOutput("rst_rsp_zero", 32'(rz[d]), 32'd1);
    checkOutput("rst_rsp_op", 32'(rop[d]), 32'd7);
    checkOutput("rst_op_count", 32'(cnt[d]), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge
  task automatic startCmd(input int d, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    int n = 0;
    cmd_op = op;
    cmd_a  = a;
    cmd_b  = b;
    cv[d]  = 1'b1;
    while (!cr[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", 32'(cr[d]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    acc_cycle = cycle;
    cv[d]  = 1'b0;
    cmd_op = 3'($urandom);
    cmd_a  = $urandom;
    cmd_b  = $urandom;
    cur_op[d] = op;
    cur_a[d]  = a;
    cur_b[d]  = b;
    checkOutput("alu_a", aa[d], a);
    checkOutput("alu_b", ab[d], b);
    checkOutput("alu_select", 32'(asel[d]), 32'(op));
    checkOutput("busy_wait", 32'(bsy[d]), 32'd1);
    checkOutput("cmd_ready_wait", 32'(cr[d]), 32'd0);
  endtask

  task automatic waitRsp(input int d);
    int n = 0;
    logic [W-1:0] exp = alu_ref(cur_op[d], cur_a[d], cur_b[d]);
    while (!rv[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("latency", 32'(n), 32'(settle_of(d) + 1));
    checkOutput("rsp_data", rd[d], exp);
    checkOutput("rsp_zero", 32'(rz[d]), 32'(exp == '0));
    checkOutput("rsp_op", 32'(rop[d]), 32'(cur_op[d]));
  endtask

  task automatic finishRsp(input int d, input int hold);
    logic [W-1:0] exp = alu_ref(cur_op[d], cur_a[d], cur_b[d]);
    for (int i = 0; i < hold; i++) begin
      checkOutput("bp_valid", 32'(rv[d]), 32'd1);
      checkOutput("bp_data", rd[d], exp);
      checkOutput("bp_cmd_ready", 32'(cr[d]), 32'd0);
      @(negedge clk);
    end
    rr[d] = 1'b1;
    @(negedge clk);
    rr[d] = 1'b0;
    exp_cnt[d] = exp_cnt[d] + 16'd1;
    checkOutput("post_valid", 32'(rv[d]), 32'd0);
    checkOutput("op_count", 32'(cnt[d]), 32'(exp_cnt[d]));
    checkOutput("post_busy", 32'(bsy[d]), 32'd0);
    checkOutput("post_data_hold", rd[d], exp);
    checkOutput("post_alu_a_hold", aa[d], cur_a[d]);
  endtask

  task automatic applyStimulus(input int d, input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input int hold);
    startCmd(d, op, a, b);
    waitRsp(d);
    finishRsp(d, hold);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int prev_acc;
    int hs_cycle;
    logic seen_rv;
    logic [2:0] op;
    logic [W-1:0] a, b;

    for (int d = 0; d < N; d++) begin
      cv[d] = 1'b0;
      rr[d] = 1'b0;
      exp_cnt[d] = 16'd0;
    end

    $display("[TB] reset");
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < N; d++) checkReset(d);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed operations");
    applyStimulus(0, 3'b010, 32'd5, 32'd7, 0);
    checkOutput("lit_add", rd[0], 32'd12);
    checkOutput("lit_add_count", 32'(cnt[0]), 32'd1);
    applyStimulus(0, 3'b011, 32'd5, 32'd7, 0);
    checkOutput("lit_lt_true", rd[0], 32'd1);
    applyStimulus(0, 3'b011, 32'd7, 32'd5, 1);
    checkOutput("lit_lt_false", rd[0], 32'd0);
    checkOutput("lit_lt_zero", 32'(rz[0]), 32'd1);
    applyStimulus(0, 3'b110, 32'h0001_0000, 32'h0001_0000, 0);
    checkOutput("lit_mul_wrap", rd[0], 32'd0);
    checkOutput("lit_mul_zero", 32'(rz[0]), 32'd1);
    applyStimulus(0, 3'b001, 32'd3, 32'd5, 2);
    checkOutput("lit_sub", rd[0], 32'hFFFF_FFFE);
    checkOutput("lit_sub_zero", 32'(rz[0]), 32'd0);

    $display("[TB] backpressure with pending command");
    startCmd(0, 3'b010, 32'd100, 32'd200);
    waitRsp(0);
    cmd_op = 3'b100;
    cmd_a  = 32'h0000_A5A5;
    cmd_b  = 32'h0000_5A5A;
    cv[0]  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkOutput("hold_data", rd[0], 32'd300);
      checkOutput("hold_valid", 32'(rv[0]), 32'd1);
      checkOutput("hold_cmd_ready", 32'(cr[0]), 32'd0);
      checkOutput("hold_alu_a", aa[0], 32'd100);
      @(negedge clk);
    end
    rr[0] = 1'b1;
    @(negedge clk);
    rr[0] = 1'b0;
    hs_cycle = cycle;
    exp_cnt[0] = exp_cnt[0] + 16'd1;
    checkOutput("hs_valid", 32'(rv[0]), 32'd0);
    checkOutput("hs_cmd_ready", 32'(cr[0]), 32'd1);
    checkOutput("hs_not_accepted", aa[0], 32'd100);
    checkOutput("hs_count", 32'(cnt[0]), 32'(exp_cnt[0]));
    startCmd(0, 3'b100, 32'h0000_A5A5, 32'h0000_5A5A);
    checkOutput("accept_after_hs", 32'(acc_cycle - hs_cycle), 32'd1);
    waitRsp(0);
    finishRsp(0, 0);
    checkOutput("lit_xor", rd[0], 32'h0000_FFFF);

    $display("[TB] reset during WAIT");
    startCmd(0, 3'b010, 32'd9, 32'd9);
    rst_n = 1'b0;
    #1;
    checkReset(0);
    seen_rv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen_rv = seen_rv | rv[0];
    end
    rst_n = 1'b1;
    for (int d = 0; d < N; d++) exp_cnt[d] = 16'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen_rv = seen_rv | rv[0] | bsy[0];
    end
    checkOutput("no_rsp_after_reset", 32'(seen_rv), 32'd0);
    checkOutput("count_after_reset", 32'(cnt[0]), 32'd0);

    $display("[TB] latency at SETTLE 0 and 15");
    applyStimulus(1, 3'b010, 32'd40, 32'd2, 0);
    checkOutput("lit_s0_add", rd[1], 32'd42);
    applyStimulus(2, 3'b101, 32'd10, 32'd3, 1);
    checkOutput("lit_s15_neg", rd[2], 32'd7);

    $display("[TB] back-to-back zero ops through op_count wrap");
    force g_dut[1].u_dut.done_count = 16'hFF80;
    @(negedge clk);
    release g_dut[1].u_dut.done_count;
    exp_cnt[1] = 16'hFF80;
    checkOutput("preload_count", 32'(cnt[1]), 32'h0000_FF80);
    prev_acc = 0;
    for (int i = 0; i < 200; i++) begin
      startCmd(1, 3'b111, $urandom, $urandom);
      if (i > 0) checkOutput("spacing", 32'(acc_cycle - prev_acc), 32'd3);
      prev_acc = acc_cycle;
      waitRsp(1);
      finishRsp(1, 0);
    end
    checkOutput("wrapped_count", 32'(cnt[1]), 32'h0000_0048);

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      int d = $urandom_range(0, N - 1);
      op = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      for (int g = 0; g < $urandom_range(0, 2); g++) @(negedge clk);
      applyStimulus(d, op, a, b, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
